// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants: pixel width, image geometry, coordinate widths.
// Used by the window generator, conv core and pooling stage.
package cnn_pkg;

    localparam int PIX_W = 8;
    localparam int IMG_W = 1280;
    localparam int IMG_H = 720;
    localparam int X_W   = 11;
    localparam int Y_W   = 10;

    typedef logic [PIX_W-1:0] pix_t;

endpackage

// File: rtl/window_gen_3x3_if.sv
// Pixel-in / window-out bundle for window_gen_3x3 (master = window producer).
// WIN_COUNT_EN adds win_count and frame_done.
interface window_gen_3x3_if;
    import cnn_pkg::*;

    logic           sof;
    logic           pix_valid;
    pix_t           pix_in;

    pix_t           w00, w01, w02;
    pix_t           w10, w11, w12;
    pix_t           w20, w21, w22;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           window_valid;
`ifdef WIN_COUNT_EN
    logic [19:0]    win_count;
    logic           frame_done;
`endif

    modport master (
        input  sof, pix_valid, pix_in,
        output w00, w01, w02, w10, w11, w12, w20, w21, w22,
        output x, y, window_valid
`ifdef WIN_COUNT_EN
        , output win_count, frame_done
`endif
    );

    modport slave (
        output sof, pix_valid, pix_in,
        input  w00, w01, w02, w10, w11, w12, w20, w21, w22,
        input  x, y, window_valid
`ifdef WIN_COUNT_EN
        , input win_count, frame_done
`endif
    );

endinterface

// File: rtl/line_buffer.sv
// One image line of pixels; the read returns the word stored before this
// cycle's write, and the write lands on the clock edge.
module line_buffer #(
    parameter  int DEPTH = cnn_pkg::IMG_W,
    parameter  int WIDTH = cnn_pkg::PIX_W,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

endmodule

// File: rtl/window_gen_3x3.sv
// Raster-scan 3x3 sliding-window generator over two line buffers.
// Optional WIN_COUNT_EN: per-frame window count and frame_done pulse.
module window_gen_3x3 #(
    parameter int IMG_W = cnn_pkg::IMG_W,
    parameter int IMG_H = cnn_pkg::IMG_H
) (
    input logic              clk,
    input logic              reset,
    window_gen_3x3_if.master win
);
    import cnn_pkg::*;

    localparam int AW = $clog2(IMG_W);

    logic [X_W-1:0] col, ec;
    logic [Y_W-1:0] row, er;
    logic           last_col, last_row, hit;
    pix_t           lb0_q, lb1_q;

    // sof forces the accepted pixel to (0,0) whatever the counters say
    always_comb begin
        ec       = win.sof ? '0 : col;
        er       = win.sof ? '0 : row;
        last_col = (ec == X_W'(IMG_W - 1));
        last_row = (er == Y_W'(IMG_H - 1));
        hit      = win.pix_valid && (ec >= X_W'(2)) && (er >= Y_W'(2));
    end

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
        .clk   (clk),
        .we    (win.pix_valid),
        .addr  (ec[AW-1:0]),
        .wdata (win.pix_in),
        .rdata (lb0_q)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk   (clk),
        .we    (win.pix_valid),
        .addr  (ec[AW-1:0]),
        .wdata (lb0_q),
        .rdata (lb1_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            col              <= '0;
            row              <= '0;
            win.window_valid <= 1'b0;
            win.x            <= '0;
            win.y            <= '0;
            win.w00 <= '0; win.w01 <= '0; win.w02 <= '0;
            win.w10 <= '0; win.w11 <= '0; win.w12 <= '0;
            win.w20 <= '0; win.w21 <= '0; win.w22 <= '0;
        end else begin
            win.window_valid <= hit;
            if (win.pix_valid) begin
                win.w00 <= win.w01; win.w01 <= win.w02; win.w02 <= lb1_q;
                win.w10 <= win.w11; win.w11 <= win.w12; win.w12 <= lb0_q;
                win.w20 <= win.w21; win.w21 <= win.w22; win.w22 <= win.pix_in;
                col <= last_col ? '0 : ec + X_W'(1);
                if (last_col) row <= last_row ? '0 : er + Y_W'(1);
                else          row <= er;
                if (hit) begin
                    win.x <= ec - X_W'(1);
                    win.y <= er - Y_W'(1);
                end
            end
        end
    end

`ifdef WIN_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            win.win_count  <= '0;
            win.frame_done <= 1'b0;
        end else begin
            win.frame_done <= hit && last_col && last_row;
            if (win.pix_valid && win.sof) win.win_count <= '0;
            else if (hit)                 win.win_count <= win.win_count + 20'd1;
        end
    end
`endif

endmodule

// File: tb/tb_window_gen_3x3.sv
// Scoreboard bench for window_gen_3x3 on an 8x6 image, pixel = base + row*8 + col.
// Covers WIN_COUNT_EN outputs when that macro is defined.
module tb_window_gen_3x3;
    import cnn_pkg::*;

    localparam int W = 8;
    localparam int H = 6;

    typedef struct {
        int x;
        int y;
        int t[9];
        int cnt;
        int done;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    window_gen_3x3_if wif();

    window_gen_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
        .clk   (clk),
        .reset (reset),
        .win   (wif)
    );

    exp_t q[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;
    int   win_seen = 0;
    bit   strobe_chk = 0;
    bit   prev_wv = 0;
    int   mc = 0, mr = 0, mcount = 0, base = 0;
    int   s0;
    int   act[9];

    task automatic check(input string name, input int got, input int req);
        tests++;
        if (got != req) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    function automatic int pv(input int r, input int c);
        return (base + r * W + c) & 255;
    endfunction

    task automatic send(input bit s);
        exp_t ne;
        if (s) begin
            mc = 0; mr = 0; mcount = 0;
        end
        wif.pix_in    = 8'(pv(mr, mc));
        wif.sof       = s;
        wif.pix_valid = 1'b1;
        if (mc >= 2 && mr >= 2) begin
            ne.x = mc - 1;
            ne.y = mr - 1;
            for (int i = 0; i < 9; i++) ne.t[i] = pv(mr - 2 + i / 3, mc - 2 + i % 3);
            mcount++;
            ne.cnt  = mcount;
            ne.done = (mc == W - 1 && mr == H - 1) ? 1 : 0;
            q.push_back(ne);
        end
        if (mc == W - 1) begin
            mc = 0;
            mr = (mr == H - 1) ? 0 : mr + 1;
        end else begin
            mc++;
        end
        @(posedge clk);
        #1;
        wif.pix_valid = 1'b0;
        wif.sof       = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input int b, input bit toggle);
        base = b;
        for (int i = 0; i < W * H; i++) begin
            send(i == 0);
            if (toggle) idle(1);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: got %0d pending windows required 0", q.size());
            q.delete();
        end
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_window_valid"}, int'(wif.window_valid), 0);
        check({tag, "_x"}, int'(wif.x), 0);
        check({tag, "_y"}, int'(wif.y), 0);
        check({tag, "_w00"}, int'(wif.w00), 0);
        check({tag, "_w11"}, int'(wif.w11), 0);
        check({tag, "_w22"}, int'(wif.w22), 0);
`ifdef WIN_COUNT_EN
        check({tag, "_win_count"}, int'(wif.win_count), 0);
        check({tag, "_frame_done"}, int'(wif.frame_done), 0);
`endif
    endtask

    always @(negedge clk) begin
        if (!reset && wif.window_valid) begin
            win_seen++;
            if (strobe_chk) check("strobe_width", int'(prev_wv), 0);
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_window: got x=%0d y=%0d required none",
                         wif.x, wif.y);
            end else begin
                e = q.pop_front();
                act[0] = int'(wif.w00); act[1] = int'(wif.w01); act[2] = int'(wif.w02);
                act[3] = int'(wif.w10); act[4] = int'(wif.w11); act[5] = int'(wif.w12);
                act[6] = int'(wif.w20); act[7] = int'(wif.w21); act[8] = int'(wif.w22);
                check("x", int'(wif.x), e.x);
                check("y", int'(wif.y), e.y);
                for (int i = 0; i < 9; i++)
                    check($sformatf("w%0d%0d@x%0d_y%0d", i / 3, i % 3, e.x, e.y), act[i], e.t[i]);
`ifdef WIN_COUNT_EN
                check("win_count", int'(wif.win_count), e.cnt);
                check("frame_done", int'(wif.frame_done), e.done);
`endif
            end
        end
`ifdef WIN_COUNT_EN
        else if (!reset) begin
            check("frame_done_idle", int'(wif.frame_done), 0);
        end
`endif
        prev_wv = wif.window_valid;
    end

    initial begin
        reset         = 1'b1;
        wif.sof       = 1'b0;
        wif.pix_valid = 1'b0;
        wif.pix_in    = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_zero("reset");
        #1;

        // continuous frame
        s0 = win_seen;
        frame(0, 0);
        drain();
        check("frame_windows", win_seen - s0, 24);

        // pix_valid toggling every cycle
        s0 = win_seen;
        strobe_chk = 1;
        frame(30, 1);
        drain();
        strobe_chk = 0;
        check("toggle_windows", win_seen - s0, 24);

        // two frames back to back
        s0 = win_seen;
        frame(60, 0);
        frame(90, 0);
        drain();
        check("b2b_windows", win_seen - s0, 48);

        // sof reasserted at (4,3)
        s0 = win_seen;
        base = 0;
        for (int i = 0; i < 3 * W + 4; i++) send(i == 0);
        frame(100, 0);
        drain();
        check("midsof_windows", win_seen - s0, 8 + 24);

        // reset for one cycle mid-row
        s0 = win_seen;
        base = 10;
        for (int i = 0; i < 2 * W + 4; i++) send(i == 0);
        drain();
        check("prereset_windows", win_seen - s0, 2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mc = 0; mr = 0; mcount = 0;
        @(negedge clk);
        check_zero("midrow_reset");
        #1;
        s0 = win_seen;
        frame(50, 0);
        drain();
        check("restart_windows", win_seen - s0, 24);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
